// File: rtl/rlwe_dmem_vec_bridge.sv
// LSU-to-word-memory bridge: splits scalar and LANE-word vector accesses into single 32-bit beats.
// Optional macro RLWE_DMEM_VEC_ERR_ABORT_EN: an errored beat ends the transaction immediately.
`timescale 1ns/1ps

`ifndef LANE
`define LANE 16
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

typedef enum logic {
   SCR1_MEM_CMD_RD = 1'b0,
   SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
   SCR1_MEM_WIDTH_BYTE   = 2'b00,
   SCR1_MEM_WIDTH_HWORD  = 2'b01,
   SCR1_MEM_WIDTH_WORD   = 2'b10,
   SCR1_MEM_WIDTH_VECTOR = 2'b11
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
   SCR1_MEM_RESP_NOTRDY = 2'b00,
   SCR1_MEM_RESP_RDY_OK = 2'b01,
   SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;

typedef logic [`LANE-1:0][31:0] type_vector;

module rlwe_dmem_vec_bridge #(
   parameter int LANE = `LANE,
   parameter int AW   = `SCR1_DMEM_AWIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsu2dmem_req,
   input  type_scr1_mem_cmd_e    lsu2dmem_cmd,
   input  type_scr1_mem_width_e  lsu2dmem_width,
   input  logic [AW-1:0]         lsu2dmem_addr,
   input  logic [LANE-1:0][31:0] lsu2dmem_wdata,
   output logic                  dmem2lsu_req_ack,
   output logic [LANE-1:0][31:0] dmem2lsu_rdata,
   output type_scr1_mem_resp_e   dmem2lsu_resp,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [AW-1:0]         mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_err
);
   localparam int IW = $clog2(LANE);
   localparam int CW = $clog2(LANE + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]            state;
   logic [CW-1:0]         cnt;
   logic                  err_flag;
   type_scr1_mem_cmd_e    cmd_q;
   type_scr1_mem_width_e  width_q;
   logic [AW-1:0]         addr_q;
   logic [LANE-1:0][31:0] wdata_q;
   logic [LANE-1:0][31:0] rbuf;

   logic [CW-1:0]         cnt_inc;
   logic [IW-1:0]         nidx;
   logic                  last_beat;
   logic                  abort;
   logic                  err_next;
   logic [31:0]           cap;
   logic [LANE-1:0][31:0] rbuf_next;

   function automatic logic [3:0] beat_be(input type_scr1_mem_width_e w, input logic [1:0] off);
      case (w)
         SCR1_MEM_WIDTH_BYTE:  beat_be = 4'b0001 << off;
         SCR1_MEM_WIDTH_HWORD: beat_be = 4'b0011 << off;
         default:              beat_be = 4'hF;
      endcase
   endfunction

   function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input logic [IW-1:0] idx);
      beat_addr = {base[AW-1:2], 2'b00} + {{(AW-IW-2){1'b0}}, idx, 2'b00};
   endfunction

   function automatic logic [31:0] beat_wdata(input type_scr1_mem_width_e w,
                                              input logic [LANE-1:0][31:0] wd,
                                              input logic [IW-1:0] idx);
      case (w)
         SCR1_MEM_WIDTH_BYTE:  beat_wdata = {4{wd[0][7:0]}};
         SCR1_MEM_WIDTH_HWORD: beat_wdata = {2{wd[0][15:0]}};
         SCR1_MEM_WIDTH_WORD:  beat_wdata = wd[0];
         default:              beat_wdata = wd[idx];
      endcase
   endfunction

   // Scalar read data is aligned down to bit 0 and zero-filled above the access width.
   function automatic logic [31:0] scalar_rdata(input type_scr1_mem_width_e w,
                                                input logic [1:0] off,
                                                input logic [31:0] d);
      logic [31:0] sh;
      sh = d >> {off, 3'b000};
      case (w)
         SCR1_MEM_WIDTH_BYTE:  scalar_rdata = {24'h000000, sh[7:0]};
         SCR1_MEM_WIDTH_HWORD: scalar_rdata = {16'h0000, sh[15:0]};
         default:              scalar_rdata = sh;
      endcase
   endfunction

   assign dmem2lsu_req_ack = (state == ST_IDLE);

   // Beat completion decode: next index, last/abort decision and the read buffer with this beat merged.
   always_comb begin
      cnt_inc  = cnt + CW'(1'b1);
      nidx     = cnt_inc[IW-1:0];
      err_next = err_flag | mem_err;
      if (width_q == SCR1_MEM_WIDTH_VECTOR) begin
         last_beat = (cnt_inc == CW'(LANE));
         cap       = mem_rdata;
      end else begin
         last_beat = 1'b1;
         cap       = scalar_rdata(width_q, addr_q[1:0], mem_rdata);
      end
`ifdef RLWE_DMEM_VEC_ERR_ABORT_EN
      abort = mem_err;
`else
      abort = 1'b0;
`endif
      rbuf_next                = rbuf;
      rbuf_next[cnt[IW-1:0]]   = cap;
   end

   // Transaction FSM with registered beat request and registered LSU response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         err_flag       <= 1'b0;
         cmd_q          <= SCR1_MEM_CMD_RD;
         width_q        <= SCR1_MEM_WIDTH_BYTE;
         addr_q         <= '0;
         wdata_q        <= '0;
         rbuf           <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_be         <= 4'h0;
         mem_addr       <= '0;
         mem_wdata      <= 32'h0;
         dmem2lsu_rdata <= '0;
         dmem2lsu_resp  <= SCR1_MEM_RESP_NOTRDY;
      end else begin
         case (state)
            ST_IDLE: begin
               if (lsu2dmem_req) begin
                  cmd_q     <= lsu2dmem_cmd;
                  width_q   <= lsu2dmem_width;
                  addr_q    <= lsu2dmem_addr;
                  wdata_q   <= lsu2dmem_wdata;
                  cnt       <= '0;
                  err_flag  <= 1'b0;
                  rbuf      <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= (lsu2dmem_cmd == SCR1_MEM_CMD_WR);
                  mem_be    <= beat_be(lsu2dmem_width, lsu2dmem_addr[1:0]);
                  mem_addr  <= beat_addr(lsu2dmem_addr, '0);
                  mem_wdata <= beat_wdata(lsu2dmem_width, lsu2dmem_wdata, '0);
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  rbuf     <= rbuf_next;
                  err_flag <= err_next;
                  cnt      <= cnt_inc;
                  if (last_beat || abort) begin
                     state         <= ST_RESP;
                     dmem2lsu_resp <= err_next ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                     if (cmd_q == SCR1_MEM_CMD_RD) begin
                        dmem2lsu_rdata <= rbuf_next;
                     end
                  end else begin
                     state     <= ST_ISSUE;
                     mem_req   <= 1'b1;
                     mem_be    <= beat_be(width_q, addr_q[1:0]);
                     mem_addr  <= beat_addr(addr_q, nidx);
                     mem_wdata <= beat_wdata(width_q, wdata_q, nidx);
                  end
               end
            end
            ST_RESP: begin
               dmem2lsu_resp <= SCR1_MEM_RESP_NOTRDY;
               state         <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rlwe_dmem_vec_bridge.sv
// Directed bench for rlwe_dmem_vec_bridge: scalar vector table plus hand-written multi-beat cases,
// driven against a zero-wait memory responder with optional ack stall and error injection.
`timescale 1ns/1ps

module tb_rlwe_dmem_vec_bridge;
   localparam int LANE = 16;
   localparam int AW   = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 lsu2dmem_req = 1'b0;
   type_scr1_mem_cmd_e   lsu2dmem_cmd = SCR1_MEM_CMD_RD;
   type_scr1_mem_width_e lsu2dmem_width = SCR1_MEM_WIDTH_BYTE;
   logic [AW-1:0]        lsu2dmem_addr = '0;
   type_vector           lsu2dmem_wdata = '0;
   logic                 dmem2lsu_req_ack;
   type_vector           dmem2lsu_rdata;
   type_scr1_mem_resp_e  dmem2lsu_resp;
   logic                 mem_req, mem_we;
   logic [3:0]           mem_be;
   logic [AW-1:0]        mem_addr;
   logic [31:0]          mem_wdata;
   logic                 mem_ack = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
   logic [31:0]          mem_rdata = 32'h0;

   int          checks = 0, errors = 0;
   int          beat_n = 0, stall_beat = -1, stall_cnt = 0, err_beat = -1;
   logic        rd_const_en = 1'b0;
   logic [31:0] rd_const = 32'h0;
   logic        pend = 1'b0;
   int          pend_beat = 0;
   logic [31:0] pend_addr = 32'h0;
   logic [68:0] saved = '0;
   logic [68:0] log_beat [0:31];

   typedef struct {
      type_scr1_mem_cmd_e   cmd;
      type_scr1_mem_width_e width;
      logic [31:0]          addr;
      logic [31:0]          wd0;
      logic [31:0]          mem_d;
      logic [3:0]           e_be;
      logic [31:0]          e_addr;
      logic [31:0]          e_wdata;
      logic [31:0]          e_rd0;
   } vec_rec_t;

   vec_rec_t tbl [7];

   rlwe_dmem_vec_bridge #(.LANE(LANE), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .lsu2dmem_req(lsu2dmem_req), .lsu2dmem_cmd(lsu2dmem_cmd), .lsu2dmem_width(lsu2dmem_width),
      .lsu2dmem_addr(lsu2dmem_addr), .lsu2dmem_wdata(lsu2dmem_wdata),
      .dmem2lsu_req_ack(dmem2lsu_req_ack), .dmem2lsu_rdata(dmem2lsu_rdata), .dmem2lsu_resp(dmem2lsu_resp),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      mem_val = rd_const_en ? rd_const : (a ^ 32'h5A5A0000);
   endfunction

   // Memory responder: acks a request on the negedge it is seen, completes it one cycle later.
   initial begin
      forever begin
         @(negedge clk);
         mem_rvalid = pend;
         mem_err    = pend && (pend_beat == err_beat);
         mem_rdata  = pend ? mem_val(pend_addr) : 32'h0;
         pend       = 1'b0;
         mem_ack    = 1'b0;
         if (beat_n == stall_beat && stall_cnt > 0) begin
            check("stall_req_held", mem_req, 1'b1);
            check("stall_fields_held", {mem_we, mem_be, mem_addr, mem_wdata}, saved);
         end
         if (mem_req) begin
            if (beat_n == stall_beat && stall_cnt < 3) begin
               if (stall_cnt == 0) saved = {mem_we, mem_be, mem_addr, mem_wdata};
               stall_cnt++;
            end else begin
               mem_ack = 1'b1;
               if (beat_n < 32) log_beat[beat_n] = {mem_we, mem_be, mem_addr, mem_wdata};
               pend      = 1'b1;
               pend_beat = beat_n;
               pend_addr = mem_addr;
               beat_n++;
            end
         end
      end
   end

   task automatic run_txn(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                          input logic [31:0] addr, input type_vector wd,
                          output int lat, output type_scr1_mem_resp_e resp, output type_vector rd);
      beat_n    = 0;
      stall_cnt = 0;
      @(negedge clk);
      check("req_ack_idle", dmem2lsu_req_ack, 1'b1);
      lsu2dmem_req   = 1'b1;
      lsu2dmem_cmd   = cmd;
      lsu2dmem_width = w;
      lsu2dmem_addr  = addr;
      lsu2dmem_wdata = wd;
      @(negedge clk);
      lsu2dmem_req = 1'b0;
      lat = 1;
      while (dmem2lsu_resp == SCR1_MEM_RESP_NOTRDY && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 200) begin
         errors++;
         $display("FAIL resp_timeout: no response within %0d cycles", lat);
      end
      resp = dmem2lsu_resp;
      rd   = dmem2lsu_rdata;
      check("req_ack_in_resp", dmem2lsu_req_ack, 1'b0);
      @(negedge clk);
      check("resp_one_cycle", dmem2lsu_resp, SCR1_MEM_RESP_NOTRDY);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      type_vector          vw, rd;
      type_scr1_mem_resp_e resp;
      int                  lat, n;
      logic                bad;
      logic [31:0]         a;

      tbl[0] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h103, 32'h0,        32'hAABBCCDD, 4'b1000, 32'h100, 32'h0,        32'h000000AA};
      tbl[1] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h202, 32'h0,        32'h11223344, 4'b1100, 32'h200, 32'h0,        32'h00001122};
      tbl[2] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h30C, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h30C, 32'h0,        32'hDEADBEEF};
      tbl[3] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h001, 32'h0,        32'hAABBCCDD, 4'b0010, 32'h000, 32'h0,        32'h000000CC};
      tbl[4] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h052, 32'h123456A7, 32'h0,        4'b0100, 32'h050, 32'hA7A7A7A7, 32'h000000CC};
      tbl[5] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h066, 32'h9876BEEF, 32'h0,        4'b1100, 32'h064, 32'hBEEFBEEF, 32'h000000CC};
      tbl[6] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h071, 32'hCAFEF00D, 32'h0,        4'b1111, 32'h070, 32'hCAFEF00D, 32'h000000CC};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_resp", dmem2lsu_resp, SCR1_MEM_RESP_NOTRDY);
      check("rst_req_ack", dmem2lsu_req_ack, 1'b1);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_be_addr", {mem_be, mem_addr, mem_wdata}, 68'h0);
      check("rst_rdata", |dmem2lsu_rdata, 1'b0);

      // Vector store: wdata[i] = i from 0x40.
      for (int i = 0; i < LANE; i++) vw[i] = 32'(i);
      run_txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h40, vw, lat, resp, rd);
      check("vst_beats", beat_n, LANE);
      check("vst_lat", lat, 2 * LANE + 1);
      check("vst_resp", resp, SCR1_MEM_RESP_RDY_OK);
      check("vst_rdata_hold", rd[5], 32'h0);
      for (int i = 0; i < LANE; i++) begin
         a = 32'h40 + 32'(4 * i);
         check($sformatf("vst_beat%0d", i), log_beat[i], {1'b1, 4'hF, a, 32'(i)});
      end

      // Vector load from 0x1000.
      run_txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h1000, vw, lat, resp, rd);
      check("vld_beats", beat_n, LANE);
      check("vld_lat", lat, 2 * LANE + 1);
      check("vld_resp", resp, SCR1_MEM_RESP_RDY_OK);
      for (int i = 0; i < LANE; i++) begin
         a = 32'h1000 + 32'(4 * i);
         check($sformatf("vld_beat%0d", i), log_beat[i][68:32], {1'b0, 4'hF, a});
         check($sformatf("vld_rdata%0d", i), rd[i], a ^ 32'h5A5A0000);
      end

      // Scalar table.
      rd_const_en = 1'b1;
      for (int k = 0; k < 7; k++) begin
         rd_const = tbl[k].mem_d;
         vw       = '1;
         vw[0]    = tbl[k].wd0;
         run_txn(tbl[k].cmd, tbl[k].width, tbl[k].addr, vw, lat, resp, rd);
         check($sformatf("row%0d_beats", k), beat_n, 1);
         check($sformatf("row%0d_lat", k), lat, 3);
         check($sformatf("row%0d_resp", k), resp, SCR1_MEM_RESP_RDY_OK);
         check($sformatf("row%0d_be", k), log_beat[0][67:64], tbl[k].e_be);
         check($sformatf("row%0d_addr", k), log_beat[0][63:32], tbl[k].e_addr);
         check($sformatf("row%0d_we", k), log_beat[0][68], tbl[k].cmd == SCR1_MEM_CMD_WR);
         if (tbl[k].cmd == SCR1_MEM_CMD_WR)
            check($sformatf("row%0d_wdata", k), log_beat[0][31:0], tbl[k].e_wdata);
         check($sformatf("row%0d_rdata0", k), rd[0], tbl[k].e_rd0);
         check($sformatf("row%0d_upper_zero", k), |rd[LANE-1:1], 1'b0);
      end
      rd_const_en = 1'b0;

      // Back-pressure: ack for beat 5 withheld for 3 cycles.
      stall_beat = 5;
      run_txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h400, vw, lat, resp, rd);
      stall_beat = -1;
      check("bp_stall_applied", stall_cnt, 3);
      check("bp_beats", beat_n, LANE);
      check("bp_lat", lat, 2 * LANE + 4);
      check("bp_resp", resp, SCR1_MEM_RESP_RDY_OK);
      for (int i = 0; i < LANE; i++)
         check($sformatf("bp_addr%0d", i), log_beat[i][63:32], 32'h400 + 32'(4 * i));
      check("bp_rdata5", rd[5], 32'h414 ^ 32'h5A5A0000);

      // Error on beat 2 of a vector load.
      err_beat = 2;
      run_txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h800, vw, lat, resp, rd);
      err_beat = -1;
      check("err_resp", resp, SCR1_MEM_RESP_RDY_ER);
      check("err_rdata0", rd[0], 32'h800 ^ 32'h5A5A0000);
      check("err_rdata2", rd[2], 32'h808 ^ 32'h5A5A0000);
`ifdef RLWE_DMEM_VEC_ERR_ABORT_EN
      check("err_beats", beat_n, 3);
      check("err_lat", lat, 7);
      check("err_rdata15", rd[15], 32'h0);
`else
      check("err_beats", beat_n, LANE);
      check("err_lat", lat, 2 * LANE + 1);
      check("err_rdata15", rd[15], 32'h83C ^ 32'h5A5A0000);
`endif

      // Address wrap: base 2^AW - 0x20.
      run_txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'hFFFFFFE0, vw, lat, resp, rd);
      check("wrap_resp", resp, SCR1_MEM_RESP_RDY_OK);
      check("wrap_addr7", log_beat[7][63:32], 32'hFFFFFFFC);
      check("wrap_addr8", log_beat[8][63:32], 32'h00000000);
      check("wrap_addr15", log_beat[15][63:32], 32'h0000001C);
      check("wrap_rdata8", rd[8], 32'h5A5A0000);

      // Reset while beat 7 of a vector store is in flight.
      for (int i = 0; i < LANE; i++) vw[i] = 32'hF0 + 32'(i);
      beat_n    = 0;
      stall_cnt = 0;
      @(negedge clk);
      lsu2dmem_req   = 1'b1;
      lsu2dmem_cmd   = SCR1_MEM_CMD_WR;
      lsu2dmem_width = SCR1_MEM_WIDTH_VECTOR;
      lsu2dmem_addr  = 32'h900;
      lsu2dmem_wdata = vw;
      @(negedge clk);
      lsu2dmem_req = 1'b0;
      n = 0;
      while (beat_n < 8 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rstmid_reached_beat7", beat_n, 8);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rstmid_mem_req", mem_req, 1'b0);
      check("rstmid_mem_fields", {mem_we, mem_be, mem_addr, mem_wdata}, 69'h0);
      check("rstmid_late_rvalid_present", mem_rvalid, 1'b1);
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (dmem2lsu_resp != SCR1_MEM_RESP_NOTRDY || mem_req) bad = 1'b1;
      end
      check("rstmid_no_response", bad, 1'b0);

      rd_const_en = 1'b1;
      rd_const    = 32'h13579BDF;
      run_txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, vw, lat, resp, rd);
      check("post_rst_beats", beat_n, 1);
      check("post_rst_lat", lat, 3);
      check("post_rst_resp", resp, SCR1_MEM_RESP_RDY_OK);
      check("post_rst_rdata0", rd[0], 32'h13579BDF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rlwe_dmem_vec_bridge.md
RLWE_DMEM_VEC_BRIDGE -- requirements
Module: rlwe_dmem_vec_bridge

Interface
REQ-001 SHALL have parameter LANE, default `LANE (16), number of 32-bit words in a type_vector.
REQ-002 SHALL have parameter AW, default `SCR1_DMEM_AWIDTH, byte address width on both sides.
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
  - clk  in  1  rising-edge clock.
  - rst  in  1  synchronous, active-high reset.
REQ-004 LSU-side ports SHALL be:
  - lsu2dmem_req  in  1  request.
  - lsu2dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR.
  - lsu2dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD/VECTOR.
  - lsu2dmem_addr  in  AW  byte address.
  - lsu2dmem_wdata  in  type_vector  store data.
  - dmem2lsu_req_ack  out  1  request accepted.
  - dmem2lsu_rdata  out  type_vector  load data.
  - dmem2lsu_resp  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER.
REQ-005 Memory-side ports SHALL be:
  - mem_req  out  1  beat request.
  - mem_we  out  1  write.
  - mem_be  out  4  byte enables.
  - mem_addr  out  AW  word-aligned address.
  - mem_wdata  out  32  write data.
  - mem_ack  in  1  beat accepted.
  - mem_rvalid  in  1  beat complete.
  - mem_rdata  in  32  read data.
  - mem_err  in  1  beat error, qualified by mem_rvalid.

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; at most one memory beat outstanding.
REQ-007 dmem2lsu_req_ack SHALL be 1 exactly when state==IDLE (combinational); a request is accepted on lsu2dmem_req & dmem2lsu_req_ack.
REQ-008 On accept, cmd, width, addr and wdata SHALL be latched, beat counter and error flag cleared, and state SHALL go IDLE->ISSUE.
REQ-009 Beat count SHALL be LANE for VECTOR and 1 for BYTE/HWORD/WORD.
REQ-010 In ISSUE, mem_req SHALL be 1 and held with stable address, be, we and wdata until mem_ack; on mem_ack state SHALL go ISSUE->WAIT.
REQ-011 Beat i address SHALL be {addr[AW-1:2],2'b00} + 4*i, wrapping modulo 2^AW.
REQ-012 VECTOR beats SHALL use mem_be=4'hF and mem_wdata=wdata[i].
REQ-013 Scalar beats SHALL use mem_wdata = wdata[0] replicated per width.
REQ-014 Scalar mem_be SHALL be:
  - BYTE: 4'b0001<<addr[1:0].
  - HWORD: 4'b0011<<addr[1:0].
  - WORD: 4'hF.
REQ-015 In WAIT, on mem_rvalid the bridge SHALL:
  - capture read data into buffer word i; scalar data is right-shifted by 8*addr[1:0] and zero-filled above width.
  - OR mem_err into the error flag.
  - increment i, then go to ISSUE if beats remain, otherwise RESP.
REQ-016 Scalar reads SHALL return 0 in words 1..LANE-1 of dmem2lsu_rdata.
REQ-017 In RESP, for exactly one cycle, dmem2lsu_resp SHALL be RDY_ER if the error flag is set, else RDY_OK; dmem2lsu_rdata SHALL be valid that cycle; state then returns to IDLE.
REQ-018 Outside RESP, dmem2lsu_resp SHALL be NOTRDY.
REQ-019 dmem2lsu_rdata SHALL hold its value until the next read response.
REQ-020 With zero-wait memory (ack in ISSUE, rvalid on the following cycle), the response SHALL appear 2*beats+1 cycles after the accept cycle: 3 cycles scalar, 2*LANE+1 cycles vector.
REQ-021 mem_ack outside ISSUE and mem_rvalid outside WAIT SHALL be ignored.
REQ-022 A new request SHALL NOT be accepted in the RESP cycle.

Reset
REQ-023 rst SHALL force, at the next clk edge:
  - state=IDLE, counter=0, error flag=0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - dmem2lsu_rdata='0, dmem2lsu_resp=NOTRDY.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no LSU response; a late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-025 Macro RLWE_DMEM_VEC_ERR_ABORT_EN SHALL control error handling:
  - Defined: mem_rvalid & mem_err on any beat skips remaining beats and goes directly to RESP with RDY_ER.
  - Undefined: all beats always complete and RDY_ER is reported at the end if any beat erred.

Verification
REQ-026 Bench SHALL cover:
  - Scalar load: BYTE read, addr 0x103, mem_rdata=0xAABBCCDD, zero-wait memory -> mem_be=4'b1000, mem_addr=0x100, rdata[0]=0x000000AA, RDY_OK 3 cycles after accept.
  - Vector store: base 0x40, LANE=16, wdata[i]=i -> 16 beats at 0x40..0x7C, be=4'hF, mem_wdata=i, RDY_OK.
  - Back-pressure: mem_ack delayed 3 cycles on beat 5 -> mem_req and all beat fields held stable, no beat skipped or repeated.
  - Beat error: mem_err on beat 2 of a vector load -> RDY_ER after beat 2 with macro defined, after beat 15 without.
  - Wrap: vector base 2^AW-0x20 -> beat 8 at address 0x0.
  - Reset during beat 7 -> mem_req=0 next cycle, no response, next request completes normally.
